// File: rtl/ddr3_dll_ctrl.sv
// ddr3_dll_ctrl: DDR3 PHY master DLL power-up, lock qualification and delay-code update sequencer
module ddr3_dll_ctrl #(
  parameter int PWRUP_WAIT    = 64,
  parameter int LOCK_FILTER   = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int UPDATE_PERIOD = 1024,
  parameter int UPD_PULSE_W   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       DLL_LOCK,
  input  logic       DLL_DELAY_DIFF,
  input  logic [7:0] DLL_CODE,
  input  logic       UPDATE_REQ,
  output logic       UPDATE_ACK,
  output logic       DLL_POWERDOWN_N,
  output logic       DLL_CODE_UPDATE,
  output logic [7:0] CODE_OUT,
  output logic       CODE_VALID,
  output logic       READY,
  output logic       ERROR,
  output logic [3:0] RELOCK_CNT
);
  localparam logic [2:0] OFF = 3'd0, PWRUP = 3'd1, WAIT_LOCK = 3'd2, UPDATE = 3'd3,
                         CAPTURE = 3'd4, RUN = 3'd5, FAULT = 3'd6;
  localparam logic [19:0] PW_END  = 20'(PWRUP_WAIT - 1);
  localparam logic [19:0] TO_END  = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] PER_END = 20'(UPDATE_PERIOD - 1);
  localparam logic [19:0] UPD_END = 20'(UPD_PULSE_W - 1);
  localparam logic [7:0]  LF_END  = 8'(LOCK_FILTER - 1);
  logic [2:0]  st, nxt;
  logic [19:0] cnt;
  logic [7:0]  filt;
  logic        lock_m, lock_s, diff_m, diff_s, diff_d;
  logic        lost, lost_n, req, diff_rise;
  assign diff_rise       = diff_s & ~diff_d;
  assign lost_n          = lost | ~lock_s;
  assign DLL_POWERDOWN_N = st != OFF && st != FAULT;
  assign DLL_CODE_UPDATE = st == UPDATE && ENABLE;
  assign UPDATE_ACK      = st == CAPTURE && req && ENABLE;
  assign READY           = CODE_VALID && (st == RUN || st == UPDATE || st == CAPTURE);
  assign ERROR           = st == FAULT;
  // next-state selection; qualification beats timeout, lock loss beats every RUN trigger
  always_comb begin
    nxt = st;
    case (st)
      OFF:       nxt = PWRUP;
      PWRUP:     nxt = cnt == PW_END ? WAIT_LOCK : PWRUP;
      WAIT_LOCK: nxt = (lock_s && filt == LF_END) ? UPDATE : cnt == TO_END ? FAULT : WAIT_LOCK;
      UPDATE:    nxt = cnt == UPD_END ? (lost_n ? WAIT_LOCK : CAPTURE) : UPDATE;
      CAPTURE:   nxt = RUN;
      RUN:       nxt = !lock_s ? WAIT_LOCK : (UPDATE_REQ || diff_rise || cnt == PER_END) ? UPDATE : RUN;
      default:   nxt = FAULT;
    endcase
    if (!ENABLE) nxt = OFF;
  end
  // two-flop synchronizers for the asynchronous DLL status flags plus diff edge history
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) {lock_m, lock_s, diff_m, diff_s, diff_d} <= '0;
    else {lock_m, lock_s, diff_m, diff_s, diff_d} <= {DLL_LOCK, lock_m, DLL_DELAY_DIFF, diff_m, diff_s};
  // state register and shared dwell counter, cleared on every state change
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      st   <= OFF;
      cnt  <= '0;
      filt <= '0;
      lost <= 1'b0;
    end else begin
      st   <= nxt;
      cnt  <= (nxt == st && st != OFF && st != FAULT) ? cnt + 20'd1 : '0;
      filt <= (st == WAIT_LOCK && nxt == WAIT_LOCK && lock_s) ? filt + 8'd1 : '0;
      lost <= st == UPDATE && nxt == UPDATE ? lost_n : 1'b0;
    end
  // published code, validity, request tracking and lock-loss accounting
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      CODE_OUT   <= '0;
      CODE_VALID <= 1'b0;
      req        <= 1'b0;
      RELOCK_CNT <= '0;
    end else begin
      if (st == CAPTURE && nxt == RUN) CODE_OUT <= DLL_CODE;
      CODE_VALID <= (nxt == OFF || nxt == WAIT_LOCK) ? 1'b0 : st == CAPTURE ? 1'b1 : CODE_VALID;
      req        <= st == RUN ? nxt == UPDATE && UPDATE_REQ : (nxt == UPDATE || nxt == CAPTURE) && req;
      if ((st == RUN || (st == UPDATE && CODE_VALID)) && nxt == WAIT_LOCK && RELOCK_CNT != 4'hF)
        RELOCK_CNT <= RELOCK_CNT + 4'd1;
    end
endmodule

// File: tb/tb_ddr3_dll_ctrl.sv
// tb_ddr3_dll_ctrl: directed cycle-accurate checks of the DLL sequencer
module tb_ddr3_dll_ctrl;
  logic       CLK = 1'b0, RESET, ENABLE, DLL_LOCK, DLL_DELAY_DIFF, UPDATE_REQ;
  logic [7:0] DLL_CODE;
  logic       UPDATE_ACK, DLL_POWERDOWN_N, DLL_CODE_UPDATE, CODE_VALID, READY, ERROR;
  logic [7:0] CODE_OUT;
  logic [3:0] RELOCK_CNT;
  int tests = 0, fails = 0, bad, n;
  ddr3_dll_ctrl #(.PWRUP_WAIT(8), .LOCK_FILTER(4), .LOCK_TIMEOUT(100), .UPDATE_PERIOD(50), .UPD_PULSE_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DLL_LOCK(DLL_LOCK), .DLL_DELAY_DIFF(DLL_DELAY_DIFF),
    .DLL_CODE(DLL_CODE), .UPDATE_REQ(UPDATE_REQ), .UPDATE_ACK(UPDATE_ACK), .DLL_POWERDOWN_N(DLL_POWERDOWN_N),
    .DLL_CODE_UPDATE(DLL_CODE_UPDATE), .CODE_OUT(CODE_OUT), .CODE_VALID(CODE_VALID), .READY(READY),
    .ERROR(ERROR), .RELOCK_CNT(RELOCK_CNT)
  );
  always #5 CLK = ~CLK;
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    RESET = 1'b1; ENABLE = 1'b0; DLL_LOCK = 1'b0; DLL_DELAY_DIFF = 1'b0; UPDATE_REQ = 1'b0; DLL_CODE = 8'h00;
    tick(3);
    chk("rst_pdn", DLL_POWERDOWN_N, 0);
    chk("rst_upd", DLL_CODE_UPDATE, 0);
    chk("rst_code", CODE_OUT, 8'h00);
    chk("rst_valid", CODE_VALID, 0);
    chk("rst_ready", READY, 0);
    chk("rst_error", ERROR, 0);
    chk("rst_relock", RELOCK_CNT, 0);
    chk("rst_ack", UPDATE_ACK, 0);
    // bring-up: cycle 0 is the period right after release
    RESET = 1'b0; ENABLE = 1'b1; DLL_CODE = 8'h5A;
    chk("c0_pdn", DLL_POWERDOWN_N, 0);
    tick();
    chk("c1_pdn", DLL_POWERDOWN_N, 1);
    tick(4);
    DLL_LOCK = 1'b1;
    tick(7);
    chk("c12_upd", DLL_CODE_UPDATE, 0);
    tick();
    chk("c13_upd", DLL_CODE_UPDATE, 1);
    tick();
    chk("c14_upd", DLL_CODE_UPDATE, 1);
    tick();
    chk("c15_upd", DLL_CODE_UPDATE, 0);
    chk("c15_ready", READY, 0);
    tick();
    chk("c16_ready", READY, 1);
    chk("c16_valid", CODE_VALID, 1);
    chk("c16_code", CODE_OUT, 8'h5A);
    // periodic update after 50 RUN cycles (c16..c65)
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 4) DLL_CODE = 8'h61;
      if (DLL_CODE_UPDATE !== 1'b0 || READY !== 1'b1) bad++;
      tick();
    end
    chk("per_quiet", bad, 0);
    chk("c66_upd", DLL_CODE_UPDATE, 1);
    chk("c66_ready", READY, 1);
    tick();
    chk("c67_upd", DLL_CODE_UPDATE, 1);
    tick();
    chk("c68_upd", DLL_CODE_UPDATE, 0);
    chk("c68_code_old", CODE_OUT, 8'h5A);
    chk("c68_ready", READY, 1);
    tick();
    chk("c69_code", CODE_OUT, 8'h61);
    // request and diff edge seen in the same RUN cycle (c72)
    tick();
    DLL_DELAY_DIFF = 1'b1; DLL_CODE = 8'h7C;
    tick(2);
    UPDATE_REQ = 1'b1;
    tick();
    chk("c73_upd", DLL_CODE_UPDATE, 1);
    chk("c73_ack", UPDATE_ACK, 0);
    tick(2);
    chk("c75_ack", UPDATE_ACK, 1);
    chk("c75_upd", DLL_CODE_UPDATE, 0);
    tick();
    UPDATE_REQ = 1'b0;
    chk("c76_ack", UPDATE_ACK, 0);
    chk("c76_code", CODE_OUT, 8'h7C);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 4) DLL_DELAY_DIFF = 1'b0;
      if (DLL_CODE_UPDATE !== 1'b0 || UPDATE_ACK !== 1'b0 || READY !== 1'b1) bad++;
      tick();
    end
    chk("diff_dropped", bad, 0);
    chk("c126_upd", DLL_CODE_UPDATE, 1);
    tick(2);
    chk("c128_noack", UPDATE_ACK, 0);
    tick();
    // lock loss for 3 cycles in RUN
    DLL_CODE = 8'h33;
    tick();
    DLL_LOCK = 1'b0;
    tick(3);
    DLL_LOCK = 1'b1;
    chk("c133_ready", READY, 0);
    chk("c133_valid", CODE_VALID, 0);
    chk("c133_relock", RELOCK_CNT, 1);
    tick(8);
    chk("c141_ready", READY, 0);
    tick();
    chk("c142_ready", READY, 1);
    chk("c142_valid", CODE_VALID, 1);
    chk("c142_code", CODE_OUT, 8'h33);
    for (int i = 0; i < 16; i++) begin
      tick();
      DLL_LOCK = 1'b0;
      tick(3);
      DLL_LOCK = 1'b1;
      n = 0;
      while (READY !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      chk("relock_ready", READY, 1);
      if (i == 0) chk("relock_2", RELOCK_CNT, 2);
    end
    chk("relock_sat", RELOCK_CNT, 15);
    // lock timeout from RUN
    DLL_LOCK = 1'b0;
    tick(102);
    chk("to_pre_err", ERROR, 0);
    chk("to_pre_pdn", DLL_POWERDOWN_N, 1);
    tick();
    chk("to_err", ERROR, 1);
    chk("to_pdn", DLL_POWERDOWN_N, 0);
    chk("to_relock", RELOCK_CNT, 15);
    tick();
    ENABLE = 1'b0;
    tick();
    chk("off_err", ERROR, 0);
    chk("off_pdn", DLL_POWERDOWN_N, 0);
    chk("off_valid", CODE_VALID, 0);
    chk("off_code", CODE_OUT, 8'h33);
    ENABLE = 1'b1;
    tick();
    chk("re_pdn", DLL_POWERDOWN_N, 1);
    chk("re_err", ERROR, 0);
    DLL_LOCK = 1'b1; DLL_CODE = 8'hC3;
    // asynchronous reset in the middle of UPDATE
    n = 0;
    while (DLL_CODE_UPDATE !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("ar_in_upd", DLL_CODE_UPDATE, 1);
    #2 RESET = 1'b1;
    #1;
    chk("ar_upd", DLL_CODE_UPDATE, 0);
    chk("ar_pdn", DLL_POWERDOWN_N, 0);
    chk("ar_code", CODE_OUT, 8'h00);
    chk("ar_relock", RELOCK_CNT, 0);
    tick();
    RESET = 1'b0;
    n = 0;
    while (READY !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("ar_ready", READY, 1);
    chk("ar_code2", CODE_OUT, 8'hC3);
    chk("ar_relock2", RELOCK_CNT, 0);
    chk("ar_err2", ERROR, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
